// File: rtl/bitsim_pkg.sv
// Shared types for the bit-sparse datapath: widths, mask/index types
// and the serializer state encoding.
package bitsim_pkg;

  localparam int MASK_W = 32;
  localparam int IDX_W  = $clog2(MASK_W);
  localparam int SEQ_W  = IDX_W + 1;

  typedef logic [MASK_W-1:0] mask_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [SEQ_W-1:0]  seq_t;

  typedef enum logic {
    SER_IDLE,
    SER_BUSY
  } ser_state_e;

endpackage

// File: rtl/bitmask_serializer_if.sv
// Mask-in / beat-out handshake bundle for bitmask_serializer.
// slave: serializer side; master: producer + consumer side.
interface bitmask_serializer_if
  import bitsim_pkg::*;
();

  mask_t in_mask;
  logic  in_valid;
  logic  in_ready;
  idx_t  out_idx;
  logic  out_nz;
  logic  out_last;
  seq_t  out_seq;
  logic  out_valid;
  logic  out_ready;

  modport slave (
    input  in_mask,
    input  in_valid,
    output in_ready,
    output out_idx,
    output out_nz,
    output out_last,
    output out_seq,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_mask,
    output in_valid,
    input  in_ready,
    input  out_idx,
    input  out_nz,
    input  out_last,
    input  out_seq,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/pencoder_32to5.sv
// 32-to-5 leading-one encoder: o_idx=0 means bit 31 set, 31 means bit 0.
// Ports: i_mask (32), o_idx (5), o_val (any bit set).
module pencoder_32to5
  import bitsim_pkg::*;
(
  input  mask_t i_mask,
  output idx_t  o_idx,
  output logic  o_val
);

  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i_mask[i]) o_idx = idx_t'(MASK_W - 1 - i);
    end
  end

  assign o_val = |i_mask;

endmodule

// File: rtl/bitmask_serializer.sv
// Serializes a 32-bit mask into one beat per set bit, MSB first.
// Ports: clk, reset (sync, active high), bus (bitmask_serializer_if.slave).
// Option: BITSER_BACK2BACK_EN lets a new mask load on the last beat.
module bitmask_serializer
  import bitsim_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  bitmask_serializer_if.slave bus
);

  ser_state_e r_state;
  ser_state_e w_state_nxt;
  mask_t      r_work;
  mask_t      w_work_nxt;
  seq_t       r_seq;
  seq_t       w_seq_nxt;

  idx_t  w_pe_idx;
  logic  w_pe_val;
  logic  w_busy;
  logic  w_last;
  logic  w_fire;
  logic  w_in_ready;
  logic  w_accept;
  mask_t w_clr;

  pencoder_32to5 u_pe (
    .i_mask (r_work),
    .o_idx  (w_pe_idx),
    .o_val  (w_pe_val)
  );

  assign w_busy = (r_state == SER_BUSY);
  // At most one bit left: this beat is the final one.
  assign w_last = ((r_work & (r_work - mask_t'(1))) == '0);
  assign w_fire = w_busy & bus.out_ready;

`ifdef BITSER_BACK2BACK_EN
  assign w_in_ready = !w_busy | (w_last & bus.out_ready);
`else
  assign w_in_ready = !w_busy;
`endif

  assign w_accept = bus.in_valid & w_in_ready;

  // Bit to drop after the current beat; nothing for an empty mask.
  always_comb begin
    w_clr = '0;
    if (w_pe_val) w_clr[MASK_W - 1 - int'(w_pe_idx)] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_seq_nxt   = r_seq;
    unique case (r_state)
      SER_IDLE: begin
        if (w_accept) begin
          w_work_nxt  = bus.in_mask;
          w_seq_nxt   = '0;
          w_state_nxt = SER_BUSY;
        end
      end
      SER_BUSY: begin
        if (w_fire) begin
          if (w_last) begin
            w_seq_nxt = '0;
            if (w_accept) begin
              w_work_nxt  = bus.in_mask;
              w_state_nxt = SER_BUSY;
            end else begin
              w_work_nxt  = '0;
              w_state_nxt = SER_IDLE;
            end
          end else begin
            w_work_nxt = r_work & ~w_clr;
            w_seq_nxt  = r_seq + seq_t'(1);
          end
        end
      end
      default: begin
        w_state_nxt = SER_IDLE;
        w_work_nxt  = '0;
        w_seq_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SER_IDLE;
      r_work  <= '0;
      r_seq   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_seq   <= w_seq_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_busy;
  assign bus.out_idx   = w_busy ? w_pe_idx : '0;
  assign bus.out_nz    = w_busy & w_pe_val;
  assign bus.out_last  = w_busy & w_last;
  assign bus.out_seq   = r_seq;

endmodule

// File: tb/tb_bitmask_serializer.sv
// Randomized self-checking bench for bitmask_serializer.
// Reference model lists set-bit positions MSB first.
module tb_bitmask_serializer;
  import bitsim_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  idx_t exp_idx[$];

  always #5 clk = ~clk;

  bitmask_serializer_if bus();

  bitmask_serializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic model(input mask_t m);
    exp_idx.delete();
    for (int b = MASK_W - 1; b >= 0; b--)
      if (m[b]) exp_idx.push_back(idx_t'(MASK_W - 1 - b));
  endtask

  // Handshake one mask; returns at the negedge where beat 0 should show.
  task automatic send_mask(input mask_t m, output bit ok);
    int g;
    g  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      ok = 1'b0;
      $display("FAIL in_ready_wait got=%b want=1", bus.in_ready);
      return;
    end
    bus.in_mask  = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_mask  = $urandom;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency out_valid got=%b want=1", bus.out_valid);
    end
  endtask

  task automatic check_beat(input string tag, input int k, input int n);
    idx_t e_idx;
    logic e_nz;
    logic e_last;
    seq_t e_seq;
    e_nz   = (exp_idx.size() > 0);
    e_idx  = e_nz ? exp_idx[k] : '0;
    e_last = (k == n - 1);
    e_seq  = seq_t'(k);
    total++;
    if (bus.out_idx !== e_idx || bus.out_nz !== e_nz ||
        bus.out_last !== e_last || bus.out_seq !== e_seq) begin
      bad++;
      $display("FAIL %s beat%0d got idx=%0d nz=%b last=%b seq=%0d want idx=%0d nz=%b last=%b seq=%0d",
               tag, k, bus.out_idx, bus.out_nz, bus.out_last, bus.out_seq,
               e_idx, e_nz, e_last, e_seq);
    end
  endtask

  // mode 0: ready always, 1: toggling, 2: random.
  task automatic run_mask(input mask_t m, input int mode, input string tag);
    int   k;
    int   n;
    int   g;
    bit   ok;
    bit   stall;
    logic r;
    logic [IDX_W+SEQ_W+2:0] saved;
    model(m);
    n = (exp_idx.size() == 0) ? 1 : exp_idx.size();
    send_mask(m, ok);
    if (!ok) return;
    k     = 0;
    g     = 0;
    stall = 1'b0;
    saved = '0;
    while (k < n && g < 400) begin
      if (stall) begin
        total++;
        if ({bus.out_valid, bus.out_idx, bus.out_nz,
             bus.out_last, bus.out_seq} !== saved) begin
          bad++;
          $display("FAIL %s stall_hold got=%h want=%h", tag,
                   {bus.out_valid, bus.out_idx, bus.out_nz,
                    bus.out_last, bus.out_seq}, saved);
        end
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (g % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      stall = 1'b0;
      if (bus.out_valid && r) begin
        check_beat(tag, k, n);
        k++;
      end else if (bus.out_valid) begin
        stall = 1'b1;
        saved = {bus.out_valid, bus.out_idx, bus.out_nz,
                 bus.out_last, bus.out_seq};
      end
      bus.in_mask = $urandom;
      @(negedge clk);
      g++;
    end
    bus.out_ready = 1'b0;
    total++;
    if (k < n) begin
      bad++;
      $display("FAIL %s beat_timeout got=%0d want=%0d", tag, k, n);
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s after_last got valid=%b rdy=%b want 0 1",
               tag, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_mask   = $urandom;
    repeat (3) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_idx !== '0 || bus.out_nz !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.out_seq !== '0) begin
      bad++;
      $display("FAIL reset got v=%b r=%b i=%0d nz=%b l=%b s=%0d want 0 1 0 0 0 0",
               bus.out_valid, bus.in_ready, bus.out_idx,
               bus.out_nz, bus.out_last, bus.out_seq);
    end
    reset = 1'b0;
  endtask

  task automatic test_two_bit();
    run_mask(32'h8000_0001, 0, "two_bit");
  endtask

  task automatic test_empty();
    run_mask(32'h0000_0000, 0, "empty");
  endtask

  task automatic test_full_stall();
    run_mask(32'hFFFF_FFFF, 1, "full");
  endtask

  task automatic test_reset_mid();
    bit ok;
    model(32'h00F0_000C);
    send_mask(32'h00F0_000C, ok);
    if (!ok) return;
    for (int k = 0; k < 2; k++) begin
      bus.out_ready = 1'b1;
      if (bus.out_valid) check_beat("rst_mid", k, exp_idx.size());
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_seq !== '0) begin
      bad++;
      $display("FAIL rst_mid got v=%b r=%b s=%0d want 0 1 0",
               bus.out_valid, bus.in_ready, bus.out_seq);
    end
    reset = 1'b0;
    run_mask(32'h0000_0001, 0, "post_rst");
  endtask

  task automatic test_back_to_back();
    mask_t mq[$];
    idx_t  bi[$];
    int    bc[$];
    int    gap;
    mq = '{32'h0000_0003, 32'h4000_0000};
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        bi.push_back(bus.out_idx);
        bc.push_back(c);
      end
      if (mq.size() > 0) begin
        bus.in_valid = 1'b1;
        bus.in_mask  = mq[0];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && bus.in_ready) void'(mq.pop_front());
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    total++;
    if (bi.size() != 3) begin
      bad++;
      $display("FAIL b2b beats got=%0d want=3", bi.size());
      return;
    end
    total++;
    if (bi[0] !== 5'd30 || bi[1] !== 5'd31 || bi[2] !== 5'd1) begin
      bad++;
      $display("FAIL b2b idx got=%0d,%0d,%0d want=30,31,1",
               bi[0], bi[1], bi[2]);
    end
`ifdef BITSER_BACK2BACK_EN
    gap = 1;
`else
    gap = 2;
`endif
    total++;
    if (bc[1] - bc[0] != 1 || bc[2] - bc[1] != gap) begin
      bad++;
      $display("FAIL b2b timing got=%0d,%0d want=1,%0d",
               bc[1] - bc[0], bc[2] - bc[1], gap);
    end
  endtask

  task automatic test_random_ignore();
    mask_t m;
    for (int i = 0; i < 8; i++) begin
      case (i % 3)
        0:       m = $urandom & $urandom & $urandom;
        1:       m = $urandom;
        default: m = mask_t'(1) << $urandom_range(0, 31);
      endcase
      run_mask(m, 2, "random");
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    test_reset();
    test_two_bit();
    test_empty();
    test_full_stall();
    test_reset_mid();
    test_back_to_back();
    test_random_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
